// File: rtl/ctr_inc_arbiter_pkg.sv
// Shared types and the rotating-priority helper for the increment arbiter.
package ctr_inc_arbiter_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_INIT  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_CLEAR = 2'd2;

   // First set bit strictly after ptr, wrapping modulo n; -1 when none.
   function automatic int rr_pick_f(
      input logic [7:0] vec,
      input int         ptr,
      input int         n
   );
      int res;
      int j;
      res = -1;
      for (int k = 8; k >= 1; k--) begin
         if (k <= n) begin
            j = (ptr + k) % n;
            if (vec[3'(j)]) res = j;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ctr_inc_arbiter_rr_pick.sv
// Combinational round-robin selector: request vector + last pointer
// give the next index to serve.
module rr_pick
   import ctr_inc_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          valid
);

   int pick;

   always_comb begin
      pick  = rr_pick_f(8'(vec), int'(ptr), N);
      valid = (pick >= 0);
      idx   = IW'(pick);
   end

endmodule

// File: rtl/ctr_inc_arbiter.sv
// Round-robin scheduler sharing one up-counter's inc among NREQ sources;
// also owns the counter reset and flags wraps and dropped requests.
module ctr_inc_arbiter
   import ctr_inc_arbiter_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int CW   = 4,
   parameter  int PW   = 2,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            async_reset,
   input  logic [NREQ-1:0] req,
   input  logic            clear,
   input  logic [CW-1:0]   count_in,
   output logic            inc_out,
   output logic            ctr_reset_n,
   output logic [IW-1:0]   grant_id,
   output logic            wrap,
   output logic [NREQ-1:0] ovf,
   output logic            busy
);

   state_t          state;
   logic [PW-1:0]   pend [NREQ];
   logic            ovf_q [NREQ];
   logic [NREQ-1:0] has_cred;
   logic [NREQ-1:0] granted;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   pick;
   logic            pick_ok;
   logic            run;
   logic            flush;
   logic            accept;
   logic            grant_en;

   assign run      = (state == ST_RUN);
   assign flush    = run && clear;
   assign accept   = run || (state == ST_CLEAR);
   assign grant_en = run && !clear && pick_ok;

   rr_pick #(
      .N  (NREQ),
      .IW (IW)
   ) u_pick (
      .vec   (has_cred),
      .ptr   (ptr),
      .idx   (pick),
      .valid (pick_ok)
   );

   // Per-requester saturating credit counters.
   for (genvar i = 0; i < NREQ; i++) begin : g_cred
      assign has_cred[i] = (pend[i] != '0);
      assign granted[i]  = grant_en && (pick == IW'(i));
      assign ovf[i]      = ovf_q[i];

      always_ff @(posedge clk) begin
         if (!async_reset || flush) begin
            pend[i]  <= '0;
            ovf_q[i] <= 1'b0;
         end else if (accept) begin
            if (req[i] && !granted[i]) begin
               if (pend[i] == '1) ovf_q[i] <= 1'b1;
               else               pend[i]  <= pend[i] + PW'(1);
            end else if (granted[i] && !req[i]) begin
               pend[i] <= pend[i] - PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!async_reset) begin
         state       <= ST_INIT;
         ctr_reset_n <= 1'b0;
         inc_out     <= 1'b0;
         grant_id    <= '0;
         wrap        <= 1'b0;
         ptr         <= IW'(NREQ - 1);
      end else begin
         wrap <= inc_out && (count_in == '1);
         unique case (state)
            ST_INIT: begin
               state       <= ST_RUN;
               ctr_reset_n <= 1'b1;
               inc_out     <= 1'b0;
            end
            ST_RUN: begin
               if (clear) begin
                  state       <= ST_CLEAR;
                  ctr_reset_n <= 1'b0;
                  inc_out     <= 1'b0;
               end else begin
                  inc_out <= pick_ok;
                  if (pick_ok) begin
                     grant_id <= pick;
                     ptr      <= pick;
                  end
               end
            end
            ST_CLEAR: begin
               state       <= ST_RUN;
               ctr_reset_n <= 1'b1;
               inc_out     <= 1'b0;
            end
            default: begin
               state       <= ST_INIT;
               ctr_reset_n <= 1'b0;
               inc_out     <= 1'b0;
            end
         endcase
      end
   end

   assign busy = (state != ST_RUN) || (|has_cred);

endmodule

// File: tb/tb_ctr_inc_arbiter.sv
// Self-checking bench: arbiter plus a 4-bit counter, compared every
// cycle against a behavioural model of the scheduler.
module tb_ctr_inc_arbiter;

   localparam int NREQ = 4;
   localparam int CW   = 4;
   localparam int PW   = 2;
   localparam int PMAX = (1 << PW) - 1;
   localparam int CMAX = (1 << CW) - 1;
   localparam int M_INIT = 0;
   localparam int M_RUN  = 1;
   localparam int M_CLR  = 2;

   logic       clk = 1'b0;
   logic       async_reset = 1'b0;
   logic [3:0] req = '0;
   logic       clear = 1'b0;
   logic [3:0] count_in = '0;
   logic       inc_out;
   logic       ctr_reset_n;
   logic [1:0] grant_id;
   logic       wrap;
   logic [3:0] ovf;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;
   int wraps_seen = 0;

   int       m_state;
   int       m_pend [NREQ];
   int       m_ptr;
   int       m_gid;
   int       m_count;
   bit       m_inc;
   bit       m_rst_n;
   bit       m_wrap;
   bit [3:0] m_ovf;

   always #5 clk = ~clk;

   ctr_inc_arbiter #(
      .NREQ (NREQ),
      .CW   (CW),
      .PW   (PW)
   ) dut (
      .clk         (clk),
      .async_reset (async_reset),
      .req         (req),
      .clear       (clear),
      .count_in    (count_in),
      .inc_out     (inc_out),
      .ctr_reset_n (ctr_reset_n),
      .grant_id    (grant_id),
      .wrap        (wrap),
      .ovf         (ovf),
      .busy        (busy)
   );

   // The shared counter this block drives.
   always_ff @(posedge clk) begin
      if (!ctr_reset_n) count_in <= '0;
      else if (inc_out) count_in <= count_in + 4'd1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int sel;
      int nxt_count;
      bit g;
      nxt_count = !m_rst_n ? 0 : (m_inc ? (m_count + 1) % (CMAX + 1) : m_count);
      if (!async_reset) begin
         m_state = M_INIT;
         foreach (m_pend[i]) m_pend[i] = 0;
         m_ptr   = NREQ - 1;
         m_inc   = 0;
         m_gid   = 0;
         m_rst_n = 0;
         m_wrap  = 0;
         m_ovf   = '0;
      end else begin
         m_wrap = m_inc && (m_count == CMAX);
         sel = -1;
         if (m_state == M_RUN && !clear) begin
            for (int k = 1; k <= NREQ; k++) begin
               int j;
               j = (m_ptr + k) % NREQ;
               if (sel < 0 && m_pend[j] > 0) sel = j;
            end
         end
         if (m_state == M_RUN && clear) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_ovf = '0;
         end else if (m_state != M_INIT) begin
            for (int i = 0; i < NREQ; i++) begin
               g = (sel == i);
               if (req[i] && !g) begin
                  if (m_pend[i] == PMAX) m_ovf[i] = 1'b1;
                  else m_pend[i]++;
               end else if (g && !req[i]) begin
                  m_pend[i]--;
               end
            end
         end
         case (m_state)
            M_INIT: begin
               m_state = M_RUN;
               m_rst_n = 1;
               m_inc   = 0;
            end
            M_RUN: begin
               if (clear) begin
                  m_state = M_CLR;
                  m_rst_n = 0;
                  m_inc   = 0;
               end else begin
                  m_inc = (sel >= 0);
                  if (sel >= 0) begin
                     m_gid = sel;
                     m_ptr = sel;
                  end
               end
            end
            default: begin
               m_state = M_RUN;
               m_rst_n = 1;
               m_inc   = 0;
            end
         endcase
      end
      m_count = nxt_count;
   endtask

   task automatic compare_all();
      int any_pend;
      any_pend = 0;
      foreach (m_pend[i]) if (m_pend[i] > 0) any_pend = 1;
      chk("inc_out", inc_out, m_inc);
      chk("grant_id", grant_id, m_gid);
      chk("ctr_reset_n", ctr_reset_n, m_rst_n);
      chk("wrap", wrap, m_wrap);
      chk("ovf", ovf, m_ovf);
      chk("busy", busy, (m_state != M_RUN) || (any_pend != 0));
      chk("count", count_in, m_count);
      if (wrap) wraps_seen++;
   endtask

   task automatic tick(input logic [3:0] r, input logic c, input logic rs);
      req = r;
      clear = c;
      async_reset = rs;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      // Reset, then the single INIT cycle.
      repeat (3) tick(4'b0000, 1'b0, 1'b0);
      chk("rst_rstn", ctr_reset_n, 0);
      chk("rst_busy", busy, 1);
      chk("rst_inc", inc_out, 0);
      tick(4'b0000, 1'b0, 1'b1);
      chk("init_rstn_hi", ctr_reset_n, 1);
      chk("init_busy0", busy, 0);
      chk("init_cnt", count_in, 0);

      // Single request.
      tick(4'b0001, 1'b0, 1'b1);
      tick(4'b0000, 1'b0, 1'b1);
      chk("single_inc", inc_out, 1);
      chk("single_gid", grant_id, 0);
      tick(4'b0000, 1'b0, 1'b1);
      chk("single_cnt", count_in, 1);

      // All requesters for three cycles.
      repeat (3) tick(4'b1111, 1'b0, 1'b1);
      repeat (15) tick(4'b0000, 1'b0, 1'b1);
      chk("rr_cnt", count_in, 13);
      chk("rr_ovf", ovf, 0);

      // Point the arbiter at 3 so requester 0 wins next.
      tick(4'b1000, 1'b0, 1'b1);
      repeat (2) tick(4'b0000, 1'b0, 1'b1);
      repeat (6) tick(4'b0101, 1'b0, 1'b1);
      chk("ovf_set", ovf, 4'b0100);
      repeat (10) tick(4'b0000, 1'b0, 1'b1);
      chk("ovf_sticky", ovf, 4'b0100);
      tick(4'b0000, 1'b1, 1'b1);
      chk("clr_ovf", ovf, 0);
      repeat (3) tick(4'b0000, 1'b0, 1'b1);
      chk("clr_cnt", count_in, 0);

      // Seventeen grants from zero.
      wraps_seen = 0;
      repeat (17) tick(4'b1000, 1'b0, 1'b1);
      repeat (3) tick(4'b0000, 1'b0, 1'b1);
      chk("wrap_pulses", wraps_seen, 1);
      chk("wrap_final", count_in, 1);

      // Clear colliding with a request while pend[1] is 2.
      repeat (2) tick(4'b0011, 1'b0, 1'b1);
      tick(4'b0010, 1'b1, 1'b1);
      chk("coll_inc0", inc_out, 0);
      tick(4'b0010, 1'b0, 1'b1);
      chk("coll_inc1", inc_out, 0);
      chk("coll_cnt", count_in, 0);
      tick(4'b0000, 1'b0, 1'b1);
      chk("coll_grant", inc_out, 1);
      chk("coll_gid", grant_id, 1);
      repeat (2) tick(4'b0000, 1'b0, 1'b1);

      // Random traffic with occasional clear and reset.
      for (int n = 0; n < 3000; n++) begin
         tick(4'($urandom), ($urandom % 16) == 0, ($urandom % 150) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
